jtag_axi_tap: RTL and testbench
===============================

Name: jtag_axi_tap

Overview:
- IEEE 1149.1 TAP controller feeding the JTAG-to-AXI-lite bridge DTM logic. Sits directly upstream of the DTMCS/DMI shift registers.
- Decodes the TMS state machine and holds the instruction register. Owns the IDCODE and BYPASS data registers.
- Emits capture/shift/update strobes and per-register select lines, and muxes the correct serial output onto TDO on the falling edge of TCK.

Parameters:
- IrLength, 5, instruction register width in bits (minimum 2).
- IdcodeValue, 32'h00000DB3, value captured into IDCODE; bit 0 must be 1.

Ports:
- tck_i  in  1  JTAG test clock.
- trst_ni  in  1  JTAG test reset.
- tms_i  in  1  test mode select, sampled on rising TCK.
- td_i  in  1  test data in.
- td_o  out  1  test data out, changes on falling TCK.
- tdo_oe_o  out  1  TDO output enable.
- testmode_i  in  1  DFT mode; tck_o = tck_i in all modes (reserved).
- tck_o  out  1  clock to DTM logic.
- dmi_clear_o  out  1  high while in Test-Logic-Reset.
- update_o  out  1  high in Update-DR.
- capture_o  out  1  high in Capture-DR.
- shift_o  out  1  high in Shift-DR.
- tdi_o  out  1  = td_i.
- dtmcs_select_o  out  1  active IR == DTMCS (0x10).
- dtmcs_tdo_i  in  1  serial out of the DTMCS register.
- dmi_select_o  out  1  active IR == DMIACCESS (0x11).
- dmi_tdo_i  in  1  serial out of the DMI register.

Behaviour:
- Reset: trst_ni, asynchronous, active-low. It resets:
  - TAP state to TestLogicReset.
  - Active IR to IDCODE (0x01); IR shift register to 0.
  - IDCODE shift register to IdcodeValue; bypass bit to 0.
  - td_o to 0 and tdo_oe_o to 0 (negedge flops included).
- Outputs at reset:
  - dmi_clear_o = 1.
  - update_o, capture_o, shift_o = 0.
  - dtmcs_select_o, dmi_select_o = 0.
- TAP FSM: 16 states, standard 1149.1 transitions on rising tck_i based on tms_i.
  - TestLogicReset→(0)RunTestIdle; RunTestIdle→(1)SelectDrScan.
  - SelectDrScan→(0)CaptureDr / (1)SelectIrScan; SelectIrScan→(0)CaptureIr / (1)TestLogicReset.
  - Capture→(0)Shift / (1)Exit1; Shift→(1)Exit1; Exit1→(0)Pause / (1)Update.
  - Pause→(1)Exit2; Exit2→(0)Shift / (1)Update.
  - Update→(0)RunTestIdle / (1)SelectDrScan.
  - Five consecutive TMS=1 reach TestLogicReset from any state.
- Strobes: update_o, capture_o and shift_o are combinational decodes of the current DR state. They are not qualified by the selects; downstream ANDs them with its select.
- IR path:
  - CaptureIr loads the IR shift register with 'b0...0101 (two LSBs = 01).
  - ShiftIr shifts {td_i, ir_shift[IrLength-1:1]}.
  - UpdateIr copies the shift register into the active IR.
  - TestLogicReset forces active IR = IDCODE.
- Instruction decode (undecoded values behave as BYPASS):
  - 0x00 BYPASS0, 0x01 IDCODE, 0x10 DTMCS, 0x11 DMIACCESS, all-ones BYPASS.
- IDCODE register: CaptureDr with IR=IDCODE loads IdcodeValue; ShiftDr shifts in td_i at the MSB.
- Bypass register: CaptureDr loads 0; ShiftDr loads td_i.
- TDO mux, selected by current state:
  - ShiftIr: ir_shift[0].
  - ShiftDr with IR=IDCODE: idcode[0].
  - ShiftDr with IR=DTMCS: dtmcs_tdo_i.
  - ShiftDr with IR=DMIACCESS: dmi_tdo_i.
  - ShiftDr otherwise: bypass bit.
- TDO timing: the mux result is registered on negedge tck_i into td_o. tdo_oe_o is registered on the same edge = (state is ShiftIr or ShiftDr).
- Latency: the first shifted bit appears on td_o half a cycle after entering the Shift state.
- Asserting trst_ni mid-shift aborts with no update; the active IR returns to IDCODE.

Decomposition:
- Shared dm package holds:
  - tap_state_e (16-entry enum).
  - Instruction constants (BYPASS0, IDCODE, DTMCS, DMIACCESS, BYPASS).
  - IR capture pattern.
- Single flat module. The FSM next-state logic is an always_comb in place; no sub-module is needed.

Test Plan:
- Pulse trst_ni low, then TMS=0 → dmi_clear_o 1→0, active IR=0x01, tdo_oe_o=0.
- Reset, go to ShiftDr, shift 32 bits → td_o yields 0x00000DB3 LSB-first, tdo_oe_o=1 during the shift only.
- Shift IR=0x11 → dmi_select_o=1 after UpdateIr. Next CaptureDr/ShiftDr/UpdateDr → capture_o, shift_o and update_o each high exactly in their state. td_o follows dmi_tdo_i delayed half a cycle.
- Shift IR=0x10 → td_o reports 0b00101 during the IR shift. Afterwards dtmcs_select_o=1 and td_o mirrors dtmcs_tdo_i.
- IR=0x1F, shift 8 bits 0xA5 → td_o gives a leading 0 then 0xA5 delayed one bit.
- From Pause-DR, hold TMS=1 for five cycles → TestLogicReset, dmi_clear_o=1, IR=IDCODE. Assert trst_ni mid-ShiftIr → IR stays IDCODE.

Source files
------------

// File: rtl/jtag_axi_tap_pkg.sv
// Shared definitions for the JTAG TAP in front of the DTMCS/DMI bridge:
// TAP state encoding, instruction opcodes and the IR capture pattern.
package jtag_axi_tap_pkg;

   typedef enum logic [3:0] {
      TestLogicReset = 4'd0,
      RunTestIdle    = 4'd1,
      SelectDrScan   = 4'd2,
      CaptureDr      = 4'd3,
      ShiftDr        = 4'd4,
      Exit1Dr        = 4'd5,
      PauseDr        = 4'd6,
      Exit2Dr        = 4'd7,
      UpdateDr       = 4'd8,
      SelectIrScan   = 4'd9,
      CaptureIr      = 4'd10,
      ShiftIr        = 4'd11,
      Exit1Ir        = 4'd12,
      PauseIr        = 4'd13,
      Exit2Ir        = 4'd14,
      UpdateIr       = 4'd15
   } tap_state_e;

   typedef enum logic [1:0] {
      SelBypass = 2'd0,
      SelIdcode = 2'd1,
      SelDtmcs  = 2'd2,
      SelDmi    = 2'd3
   } dr_sel_e;

   localparam logic [4:0] IR_BYPASS0   = 5'h00;
   localparam logic [4:0] IR_IDCODE    = 5'h01;
   localparam logic [4:0] IR_DTMCS     = 5'h10;
   localparam logic [4:0] IR_DMIACCESS = 5'h11;
   localparam logic [4:0] IR_BYPASS    = 5'h1F;

   // Two LSBs must read 01 during Capture-IR.
   localparam logic [4:0] IR_CAPTURE   = 5'b00101;

endpackage

// File: rtl/jtag_axi_tap.sv
// IEEE 1149.1 TAP controller: TMS state machine, instruction register,
// IDCODE/BYPASS data registers and the negedge TDO mux for the DTM.
module jtag_axi_tap
   import jtag_axi_tap_pkg::*;
#(
   parameter int unsigned IrLength    = 5,
   parameter logic [31:0] IdcodeValue = 32'h00000DB3
) (
   input  logic tck_i,
   input  logic trst_ni,
   input  logic tms_i,
   input  logic td_i,
   output logic td_o,
   output logic tdo_oe_o,
   input  logic testmode_i,
   output logic tck_o,
   output logic dmi_clear_o,
   output logic update_o,
   output logic capture_o,
   output logic shift_o,
   output logic tdi_o,
   output logic dtmcs_select_o,
   input  logic dtmcs_tdo_i,
   output logic dmi_select_o,
   input  logic dmi_tdo_i
);

   tap_state_e            tap_state_r, tap_state_next_s;
   logic [IrLength-1:0]   ir_shift_r, ir_r;
   logic [31:0]           idcode_r;
   logic                  bypass_r;
   logic                  tdo_mux_s, td_r, tdo_oe_r;
   dr_sel_e               dr_sel_s;
   logic                  unused_testmode_s;

   assign unused_testmode_s = testmode_i;
   assign tck_o             = tck_i;
   assign tdi_o             = td_i;

   // Next-state decode of the 16-state TAP machine
   always_comb begin
      tap_state_next_s = TestLogicReset;
      case (tap_state_r)
         TestLogicReset: tap_state_next_s = tms_i ? TestLogicReset : RunTestIdle;
         RunTestIdle:    tap_state_next_s = tms_i ? SelectDrScan   : RunTestIdle;
         SelectDrScan:   tap_state_next_s = tms_i ? SelectIrScan   : CaptureDr;
         CaptureDr:      tap_state_next_s = tms_i ? Exit1Dr        : ShiftDr;
         ShiftDr:        tap_state_next_s = tms_i ? Exit1Dr        : ShiftDr;
         Exit1Dr:        tap_state_next_s = tms_i ? UpdateDr       : PauseDr;
         PauseDr:        tap_state_next_s = tms_i ? Exit2Dr        : PauseDr;
         Exit2Dr:        tap_state_next_s = tms_i ? UpdateDr       : ShiftDr;
         UpdateDr:       tap_state_next_s = tms_i ? SelectDrScan   : RunTestIdle;
         SelectIrScan:   tap_state_next_s = tms_i ? TestLogicReset : CaptureIr;
         CaptureIr:      tap_state_next_s = tms_i ? Exit1Ir        : ShiftIr;
         ShiftIr:        tap_state_next_s = tms_i ? Exit1Ir        : ShiftIr;
         Exit1Ir:        tap_state_next_s = tms_i ? UpdateIr       : PauseIr;
         PauseIr:        tap_state_next_s = tms_i ? Exit2Ir        : PauseIr;
         Exit2Ir:        tap_state_next_s = tms_i ? UpdateIr       : ShiftIr;
         UpdateIr:       tap_state_next_s = tms_i ? SelectDrScan   : RunTestIdle;
         default:        tap_state_next_s = TestLogicReset;
      endcase
   end

   // TAP state register
   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) tap_state_r <= TestLogicReset;
      else          tap_state_r <= tap_state_next_s;
   end

   // Instruction register; entering Test-Logic-Reset restores IDCODE at once
   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         ir_shift_r <= '0;
         ir_r       <= IrLength'(IR_IDCODE);
      end else begin
         if (tap_state_r == CaptureIr)    ir_shift_r <= IrLength'(IR_CAPTURE);
         else if (tap_state_r == ShiftIr) ir_shift_r <= {td_i, ir_shift_r[IrLength-1:1]};
         if (tap_state_next_s == TestLogicReset) ir_r <= IrLength'(IR_IDCODE);
         else if (tap_state_r == UpdateIr)       ir_r <= ir_shift_r;
      end
   end

   // Instruction decode; anything not recognised falls back to BYPASS
   always_comb begin
      dr_sel_s = SelBypass;
      if (ir_r == IrLength'(IR_IDCODE))         dr_sel_s = SelIdcode;
      else if (ir_r == IrLength'(IR_DTMCS))     dr_sel_s = SelDtmcs;
      else if (ir_r == IrLength'(IR_DMIACCESS)) dr_sel_s = SelDmi;
      else if (ir_r == IrLength'(IR_BYPASS0))   dr_sel_s = SelBypass;
      else if (ir_r == IrLength'(IR_BYPASS))    dr_sel_s = SelBypass;
      else                                      dr_sel_s = SelBypass;
   end

   // IDCODE and BYPASS data registers
   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         idcode_r <= IdcodeValue;
         bypass_r <= 1'b0;
      end else if (tap_state_r == CaptureDr) begin
         if (dr_sel_s == SelIdcode) idcode_r <= IdcodeValue;
         bypass_r <= 1'b0;
      end else if (tap_state_r == ShiftDr) begin
         if (dr_sel_s == SelIdcode) idcode_r <= {td_i, idcode_r[31:1]};
         bypass_r <= td_i;
      end
   end

   // Serial output source for the current shift state
   always_comb begin
      tdo_mux_s = 1'b0;
      case (tap_state_r)
         ShiftIr: tdo_mux_s = ir_shift_r[0];
         ShiftDr: begin
            case (dr_sel_s)
               SelIdcode: tdo_mux_s = idcode_r[0];
               SelDtmcs:  tdo_mux_s = dtmcs_tdo_i;
               SelDmi:    tdo_mux_s = dmi_tdo_i;
               default:   tdo_mux_s = bypass_r;
            endcase
         end
         default: tdo_mux_s = 1'b0;
      endcase
   end

   // TDO and its enable launch on the falling edge
   always_ff @(negedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         td_r     <= 1'b0;
         tdo_oe_r <= 1'b0;
      end else begin
         td_r     <= tdo_mux_s;
         tdo_oe_r <= (tap_state_r == ShiftIr) || (tap_state_r == ShiftDr);
      end
   end

   assign td_o           = td_r;
   assign tdo_oe_o       = tdo_oe_r;
   assign dmi_clear_o    = (tap_state_r == TestLogicReset);
   assign capture_o      = (tap_state_r == CaptureDr);
   assign shift_o        = (tap_state_r == ShiftDr);
   assign update_o       = (tap_state_r == UpdateDr);
   assign dtmcs_select_o = (dr_sel_s == SelDtmcs);
   assign dmi_select_o   = (dr_sel_s == SelDmi);

endmodule

// File: tb/tb_jtag_axi_tap.sv
// Self-checking bench for jtag_axi_tap: drives TMS/TDI scans and compares
// TDO, enables, strobes and selects against a scan-level reference model.
module tb_jtag_axi_tap;

   localparam logic [31:0] IDCODE_VAL = 32'h00000DB3;
   localparam logic [4:0]  IR_CAP     = 5'b00101;

   logic tck = 1'b0, trst_ni = 1'b0, tms_i = 1'b1, td_i = 1'b0, testmode_i = 1'b0;
   logic dtmcs_tdo_i = 1'b0, dmi_tdo_i = 1'b0;
   logic td_o, tdo_oe_o, tck_o, dmi_clear_o, update_o, capture_o, shift_o, tdi_o;
   logic dtmcs_select_o, dmi_select_o;

   int tests_run = 0;
   int fails     = 0;

   logic [4:0] model_ir;
   logic [2:0] strobe_q[$];

   jtag_axi_tap dut (
      .tck_i(tck), .trst_ni(trst_ni), .tms_i(tms_i), .td_i(td_i), .td_o(td_o),
      .tdo_oe_o(tdo_oe_o), .testmode_i(testmode_i), .tck_o(tck_o),
      .dmi_clear_o(dmi_clear_o), .update_o(update_o), .capture_o(capture_o),
      .shift_o(shift_o), .tdi_o(tdi_o), .dtmcs_select_o(dtmcs_select_o),
      .dtmcs_tdo_i(dtmcs_tdo_i), .dmi_select_o(dmi_select_o), .dmi_tdo_i(dmi_tdo_i)
   );

   always #5 tck = ~tck;

   // Entered and left at negedge+1: drive, cross the rising edge, then sample
   // after the following falling edge.
   task automatic step(input logic tms, input logic tdi);
      tms_i = tms;
      td_i  = tdi;
      @(posedge tck);
      @(negedge tck);
      #1;
   endtask

   // From Run-Test/Idle: shift v into IR, return to Run-Test/Idle.
   task automatic scan_ir(input logic [4:0] v, output logic [4:0] tdo_bits,
                          output logic [4:0] oe_bits);
      step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tdo_bits[i] = td_o;
         oe_bits[i]  = tdo_oe_o;
         step(i == 4, v[i]);
      end
      step(1'b1, 1'b0); step(1'b0, 1'b0);
      model_ir = v;
   endtask

   // From Run-Test/Idle: n-bit DR scan; ext[i] is presented on both external
   // serial inputs during the half cycle before bit i reaches td_o.
   task automatic dr_scan(input int n, input logic [63:0] din, input logic [63:0] ext,
                          output logic [63:0] dout, output int oe_cnt, output logic oe_after);
      dout   = '0;
      oe_cnt = 0;
      strobe_q.delete();
      step(1'b1, 1'b0); strobe_q.push_back({capture_o, shift_o, update_o});
      step(1'b0, 1'b0); strobe_q.push_back({capture_o, shift_o, update_o});
      dtmcs_tdo_i = ext[0]; dmi_tdo_i = ext[0];
      step(1'b0, 1'b0);
      for (int i = 0; i < n; i++) begin
         strobe_q.push_back({capture_o, shift_o, update_o});
         dout[i] = td_o;
         if (tdo_oe_o) oe_cnt++;
         if (i < n - 1) begin
            dtmcs_tdo_i = ext[i+1]; dmi_tdo_i = ext[i+1];
         end
         step(i == n - 1, din[i]);
      end
      strobe_q.push_back({capture_o, shift_o, update_o});
      oe_after = tdo_oe_o;
      step(1'b1, 1'b0); strobe_q.push_back({capture_o, shift_o, update_o});
      step(1'b0, 1'b0); strobe_q.push_back({capture_o, shift_o, update_o});
   endtask

   // Reference: what a DR scan of n bits must produce for the modelled IR.
   function automatic logic [63:0] expect_dr(input int n, input logic [63:0] din,
                                             input logic [63:0] ext);
      logic [63:0] r;
      logic [63:0] mask;
      case (model_ir)
         5'h01:        r = {din[31:0], IDCODE_VAL};
         5'h10, 5'h11: r = ext;
         default:      r = {din[62:0], 1'b0};
      endcase
      mask = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
      return r & mask;
   endfunction

   task automatic test_reset();
      tms_i = 1'b1;
      trst_ni = 1'b0;
      #2;
      tests_run++;
      if ({dmi_clear_o, capture_o, shift_o, update_o} !== 4'b1000) begin
         fails++; $display("FAIL reset_strobes got %b want 1000", {dmi_clear_o, capture_o, shift_o, update_o});
      end
      tests_run++;
      if ({dtmcs_select_o, dmi_select_o, td_o, tdo_oe_o} !== 4'b0000) begin
         fails++; $display("FAIL reset_sel_tdo got %b want 0000", {dtmcs_select_o, dmi_select_o, td_o, tdo_oe_o});
      end
      trst_ni = 1'b1;
      @(negedge tck); #1;
      step(1'b0, 1'b1);
      model_ir = 5'h01;
      tests_run++;
      if (dmi_clear_o !== 1'b0 || tdo_oe_o !== 1'b0) begin
         fails++; $display("FAIL reset_leave got clear=%b oe=%b want 0 0", dmi_clear_o, tdo_oe_o);
      end
      tests_run++;
      if (tdi_o !== td_i || tck_o !== tck) begin
         fails++; $display("FAIL passthru got tdi=%b tck=%b want %b %b", tdi_o, tck_o, td_i, tck);
      end
   endtask

   task automatic test_idcode();
      logic [63:0] din, dout;
      int oe_cnt;
      logic oe_after;
      din = {$urandom, $urandom};
      dr_scan(64, din, 64'd0, dout, oe_cnt, oe_after);
      tests_run++;
      if (dout !== expect_dr(64, din, 64'd0)) begin
         fails++; $display("FAIL idcode_shift got %h want %h", dout, expect_dr(64, din, 64'd0));
      end
      tests_run++;
      if (oe_cnt != 64 || oe_after !== 1'b0) begin
         fails++; $display("FAIL idcode_oe got cnt=%0d after=%b want 64 0", oe_cnt, oe_after);
      end
   endtask

   task automatic test_dtmcs();
      logic [4:0] tb, ob;
      logic [63:0] ext, dout;
      int n, oe_cnt;
      logic oe_after;
      scan_ir(5'h10, tb, ob);
      tests_run++;
      if (tb !== IR_CAP || ob !== 5'b11111) begin
         fails++; $display("FAIL ir_capture got tdo=%b oe=%b want %b 11111", tb, ob, IR_CAP);
      end
      tests_run++;
      if (dtmcs_select_o !== 1'b1 || dmi_select_o !== 1'b0) begin
         fails++; $display("FAIL dtmcs_sel got %b%b want 10", dtmcs_select_o, dmi_select_o);
      end
      for (int k = 0; k < 3; k++) begin
         n   = int'($urandom_range(4, 24));
         ext = {$urandom, $urandom};
         dr_scan(n, 64'd0, ext, dout, oe_cnt, oe_after);
         tests_run++;
         if (dout !== expect_dr(n, 64'd0, ext)) begin
            fails++; $display("FAIL dtmcs_mirror got %h want %h", dout, expect_dr(n, 64'd0, ext));
         end
      end
   endtask

   task automatic test_dmi();
      logic [4:0] tb, ob;
      logic [63:0] ext, dout;
      logic [2:0] exp_q[$];
      int n, oe_cnt;
      logic oe_after;
      scan_ir(5'h11, tb, ob);
      tests_run++;
      if (dmi_select_o !== 1'b1 || dtmcs_select_o !== 1'b0) begin
         fails++; $display("FAIL dmi_sel got %b%b want 01", dtmcs_select_o, dmi_select_o);
      end
      n   = int'($urandom_range(5, 40));
      ext = {$urandom, $urandom};
      dr_scan(n, {$urandom, $urandom}, ext, dout, oe_cnt, oe_after);
      tests_run++;
      if (dout !== expect_dr(n, 64'd0, ext)) begin
         fails++; $display("FAIL dmi_mirror got %h want %h", dout, expect_dr(n, 64'd0, ext));
      end
      // Expected {capture,shift,update} per sampled state of the scan
      exp_q = {3'b000, 3'b100};
      for (int i = 0; i < n; i++) exp_q.push_back(3'b010);
      exp_q.push_back(3'b000); exp_q.push_back(3'b001); exp_q.push_back(3'b000);
      tests_run++;
      if (strobe_q != exp_q) begin
         fails++; $display("FAIL dr_strobes got %p want %p", strobe_q, exp_q);
      end
   endtask

   task automatic test_bypass();
      logic [4:0] tb, ob, ir;
      logic [63:0] din, dout;
      int oe_cnt;
      logic oe_after;
      scan_ir(5'h1F, tb, ob);
      din = 64'h00000000000000A5;
      dr_scan(9, din, 64'd0, dout, oe_cnt, oe_after);
      tests_run++;
      if (dout[8:0] !== 9'h14A) begin
         fails++; $display("FAIL bypass_a5 got %h want 14a", dout[8:0]);
      end
      for (int k = 0; k < 4; k++) begin
         do ir = 5'($urandom); while (ir == 5'h01 || ir == 5'h10 || ir == 5'h11);
         scan_ir(ir, tb, ob);
         din = {32'd0, $urandom};
         dr_scan(17, din, {$urandom, $urandom}, dout, oe_cnt, oe_after);
         tests_run++;
         if (dout !== expect_dr(17, din, 64'd0) || dmi_select_o !== 1'b0 || dtmcs_select_o !== 1'b0) begin
            fails++; $display("FAIL bypass_ir%h got %h want %h", ir, dout, expect_dr(17, din, 64'd0));
         end
      end
   endtask

   task automatic test_pause_reset();
      logic [4:0] tb, ob;
      logic [63:0] din, dout;
      int oe_cnt;
      logic oe_after;
      scan_ir(5'h11, tb, ob);
      step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
      model_ir = 5'h01;
      tests_run++;
      if (dmi_clear_o !== 1'b1 || dmi_select_o !== 1'b0 || dtmcs_select_o !== 1'b0) begin
         fails++; $display("FAIL tms_reset got clear=%b dmi=%b dtmcs=%b want 1 0 0", dmi_clear_o, dmi_select_o, dtmcs_select_o);
      end
      step(1'b0, 1'b0);
      din = {32'd0, $urandom};
      dr_scan(32, din, 64'd0, dout, oe_cnt, oe_after);
      tests_run++;
      if (dout !== expect_dr(32, din, 64'd0)) begin
         fails++; $display("FAIL tms_reset_idcode got %h want %h", dout, expect_dr(32, din, 64'd0));
      end
   endtask

   task automatic test_trst_mid_shift();
      logic [63:0] din, dout;
      int oe_cnt;
      logic oe_after;
      step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
      step(1'b0, 1'b1); step(1'b0, 1'b0);
      tms_i   = 1'b1;
      trst_ni = 1'b0;
      #2;
      tests_run++;
      if (dmi_clear_o !== 1'b1 || tdo_oe_o !== 1'b0 || td_o !== 1'b0) begin
         fails++; $display("FAIL trst_abort got clear=%b oe=%b tdo=%b want 1 0 0", dmi_clear_o, tdo_oe_o, td_o);
      end
      trst_ni = 1'b1;
      @(negedge tck); #1;
      step(1'b0, 1'b0);
      model_ir = 5'h01;
      din = {32'd0, $urandom};
      dr_scan(32, din, 64'd0, dout, oe_cnt, oe_after);
      tests_run++;
      if (dout !== expect_dr(32, din, 64'd0) || dmi_select_o !== 1'b0) begin
         fails++; $display("FAIL trst_ir_idcode got %h dmi=%b want %h 0", dout, dmi_select_o, expect_dr(32, din, 64'd0));
      end
   endtask

   initial begin
      @(negedge tck); #1;
      test_reset();
      test_idcode();
      test_dtmcs();
      test_dmi();
      test_bypass();
      test_pause_reset();
      test_trst_mid_shift();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
